// File: rtl/video_pkg.sv
// Shared timing constants and types for the raster timing generator.
// Defaults describe 640x480@60 (800x525 total, negative syncs).
package video_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam bit POL_LOW  = 1'b0;
    localparam bit POL_HIGH = 1'b1;

    localparam int CW_DEF = 12;

    typedef logic [CW_DEF-1:0] coord_t;

    // Sum of the four segments of one axis
    function automatic int axis_total(input int act, input int fp, input int sync, input int bp);
        return act + fp + sync + bp;
    endfunction

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register with a parameterised reset word. Used to push
// de/hsync/vsync (and the test pattern) forward so they meet the pixel
// pipeline's r/g/b. DEPTH=0 is a plain wire. While rst_n is low every stage
// holds RST_VAL, so no stale sync level can leak out during reset.
module sync_delay #(
    parameter int             DEPTH   = 2,
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_pix,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_pix ^ rst_n;
        assign dout = din;
    end else begin : g_pipe
        logic [W-1:0] stage [DEPTH];

        // Shift one stage per clock; reset loads the inactive word everywhere
        always_ff @(posedge clk_pix) begin
            if (!rst_n) begin
                for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
            end else begin
                stage[0] <= din;
                for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
            end
        end

        assign dout = stage[DEPTH-1];
    end

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator feeding the HDMI/TMDS stage.
// x/y and the flags are look-ahead (undelayed); de/hsync/vsync are delayed by
// LATENCY clocks to line up with the pixel pipeline output.
// Optional colour-bar source: define VIDEO_TIMING_PATTERN_EN to add pat_r/g/b.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit H_POL    = POL_LOW,
    parameter bit V_POL    = POL_LOW,
    parameter int LATENCY  = 2,
    parameter int CW       = CW_DEF
) (
    input  logic          clk_pix,
    input  logic          rst_n,
    output logic [CW-1:0] x,
    output logic [CW-1:0] y,
    output logic          active,
    output logic          line_start,
    output logic          frame_start,
    output logic          vblank,
    output logic          de,
    output logic          hsync,
    output logic          vsync
`ifdef VIDEO_TIMING_PATTERN_EN
    ,
    output logic [7:0]    pat_r,
    output logic [7:0]    pat_g,
    output logic [7:0]    pat_b
`endif
);

    localparam int H_TOTAL  = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    if ((((H_TOTAL - 1) >> CW) != 0) || (((V_TOTAL - 1) >> CW) != 0)) begin : g_cw_err
        $error("video_timing_gen: CW=%0d cannot hold H_TOTAL-1=%0d / V_TOTAL-1=%0d",
               CW, H_TOTAL - 1, V_TOTAL - 1);
    end
    if (LATENCY < 0 || LATENCY > 15) begin : g_lat_err
        $error("video_timing_gen: LATENCY=%0d outside 0..15", LATENCY);
    end

    // Free-running position; x/y below are this value registered once more so
    // that the first clock after reset presents (0,0) with frame_start high.
    logic [CW-1:0] cnt_x, cnt_y;
    logic          h_last, v_last;
    logic          act_n, hs_n, vs_n;
    logic          hs_raw, vs_raw;
    logic [2:0]    dly_out;

    assign h_last = (cnt_x == CW'(H_TOTAL - 1));
    assign v_last = (cnt_y == CW'(V_TOTAL - 1));
    assign act_n  = (cnt_x < CW'(H_ACTIVE)) && (cnt_y < CW'(V_ACTIVE));
    assign hs_n   = ((cnt_x >= CW'(HS_START)) && (cnt_x < CW'(HS_END))) ? H_POL : ~H_POL;
    assign vs_n   = ((cnt_y >= CW'(VS_START)) && (cnt_y < CW'(VS_END))) ? V_POL : ~V_POL;

    // Raster counters: x wraps at H_TOTAL-1 and carries into y; both wrap together at frame end
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            cnt_x <= '0;
            cnt_y <= '0;
        end else if (h_last) begin
            cnt_x <= '0;
            cnt_y <= v_last ? '0 : cnt_y + 1'b1;
        end else begin
            cnt_x <= cnt_x + 1'b1;
        end
    end

    // Registered look-ahead coordinates and flags, plus raw sync levels for the delay line
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            x           <= '0;
            y           <= '0;
            active      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            vblank      <= 1'b0;
            hs_raw      <= ~H_POL;
            vs_raw      <= ~V_POL;
        end else begin
            x           <= cnt_x;
            y           <= cnt_y;
            active      <= act_n;
            line_start  <= (cnt_x == '0);
            frame_start <= (cnt_x == '0) && (cnt_y == '0);
            vblank      <= (cnt_y >= CW'(V_ACTIVE));
            hs_raw      <= hs_n;
            vs_raw      <= vs_n;
        end
    end

    sync_delay #(
        .DEPTH   (LATENCY),
        .W       (3),
        .RST_VAL ({1'b0, ~H_POL, ~V_POL})
    ) u_sync_delay (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .din     ({active, hs_raw, vs_raw}),
        .dout    (dly_out)
    );

    assign {de, hsync, vsync} = dly_out;

`ifdef VIDEO_TIMING_PATTERN_EN
    // Eight equal bars; bar index bits map directly onto the colour order
    // white, yellow, cyan, green, magenta, red, blue, black.
    logic [2:0]  bar_idx;
    logic [23:0] pat_raw, pat_dly;

    assign bar_idx = 3'(cnt_x / CW'(H_ACTIVE / 8));

    // Registered bar colour, forced to black outside the visible region
    always_ff @(posedge clk_pix) begin
        if (!rst_n) begin
            pat_raw <= '0;
        end else if (act_n) begin
            pat_raw <= {{8{~bar_idx[1]}}, {8{~bar_idx[2]}}, {8{~bar_idx[0]}}};
        end else begin
            pat_raw <= '0;
        end
    end

    sync_delay #(
        .DEPTH   (LATENCY),
        .W       (24),
        .RST_VAL (24'h000000)
    ) u_pat_delay (
        .clk_pix (clk_pix),
        .rst_n   (rst_n),
        .din     (pat_raw),
        .dout    (pat_dly)
    );

    assign {pat_r, pat_g, pat_b} = pat_dly;
`endif

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen. Three instances share clock and reset:
//   dut_a: default 640x480 timing, LATENCY=2
//   dut_b: 640-wide lines, short frame, active-high syncs, LATENCY=0 (+pattern)
//   dut_c: tiny 24x12 raster, LATENCY=3, used for whole-frame and wrap checks
module tb_video_timing_gen;
    import video_pkg::*;

`ifdef VIDEO_TIMING_PATTERN_EN
    localparam int WB = 27;
`else
    localparam int WB = 3;
`endif

    // ---------------- clock / reset ----------------
    logic clk_pix = 1'b0;
    logic rst_n   = 1'b0;
    always #5 clk_pix = ~clk_pix;

    initial begin
        #2000000;
        $display("FAIL watchdog: bench did not reach its summary in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- DUT wiring ----------------
    logic [11:0] a_x, a_y, b_x, b_y, c_x, c_y;
    logic a_act, a_ls, a_fs, a_vb, a_de, a_hs, a_vs;
    logic b_act, b_ls, b_fs, b_vb, b_de, b_hs, b_vs;
    logic c_act, c_ls, c_fs, c_vb, c_de, c_hs, c_vs;
`ifdef VIDEO_TIMING_PATTERN_EN
    logic [7:0] a_pr, a_pg, a_pb, b_pr, b_pg, b_pb, c_pr, c_pg, c_pb;
`endif

    video_timing_gen #(.LATENCY(2)) dut_a (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(a_x), .y(a_y), .active(a_act),
        .line_start(a_ls), .frame_start(a_fs), .vblank(a_vb),
        .de(a_de), .hsync(a_hs), .vsync(a_vs)
`ifdef VIDEO_TIMING_PATTERN_EN
        , .pat_r(a_pr), .pat_g(a_pg), .pat_b(a_pb)
`endif
    );

    video_timing_gen #(
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .H_POL(POL_HIGH), .V_POL(POL_HIGH), .LATENCY(0)
    ) dut_b (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(b_x), .y(b_y), .active(b_act),
        .line_start(b_ls), .frame_start(b_fs), .vblank(b_vb),
        .de(b_de), .hsync(b_hs), .vsync(b_vs)
`ifdef VIDEO_TIMING_PATTERN_EN
        , .pat_r(b_pr), .pat_g(b_pg), .pat_b(b_pb)
`endif
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(2), .LATENCY(3)
    ) dut_c (
        .clk_pix(clk_pix), .rst_n(rst_n), .x(c_x), .y(c_y), .active(c_act),
        .line_start(c_ls), .frame_start(c_fs), .vblank(c_vb),
        .de(c_de), .hsync(c_hs), .vsync(c_vs)
`ifdef VIDEO_TIMING_PATTERN_EN
        , .pat_r(c_pr), .pat_g(c_pg), .pat_b(c_pb)
`endif
    );

    // ---------------- reference model ----------------
    typedef struct {
        int x;
        int y;
        bit v;
    } m_t;

    m_t ma, mb, mc;

    logic [23:0] bar_rgb [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                                 24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    // Scoreboard queues of expected {de,hsync,vsync[,pattern]} words
    logic [2:0]    exp_qa [$];
    logic [WB-1:0] exp_qb [$];
    logic [2:0]    exp_qc [$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Position presented after an edge: reset -> idle, first run edge -> (0,0), then advance
    function automatic m_t m_next(input m_t m, input bit rst, input int ht, input int vt);
        m_t n;
        n = m;
        if (rst) begin
            n.x = 0; n.y = 0; n.v = 1'b0;
        end else if (!m.v) begin
            n.v = 1'b1;
        end else if (m.x == ht - 1) begin
            n.x = 0;
            n.y = (m.y == vt - 1) ? 0 : m.y + 1;
        end else begin
            n.x = m.x + 1;
        end
        return n;
    endfunction

    function automatic logic [27:0] m_undel(input m_t m, input int ha, input int va);
        logic [27:0] w;
        w = '0;
        if (m.v)
            w = {12'(m.x), 12'(m.y), (m.x < ha) && (m.y < va), m.x == 0,
                 (m.x == 0) && (m.y == 0), m.y >= va};
        return w;
    endfunction

    function automatic logic [2:0] m_sync(input m_t m, input int ha, input int va,
                                          input int hs0, input int hs1, input int vs0,
                                          input int vs1, input bit hp, input bit vp);
        logic [2:0] w;
        w = {1'b0, ~hp, ~vp};
        if (m.v)
            w = {(m.x < ha) && (m.y < va),
                 (m.x >= hs0 && m.x < hs1) ? hp : ~hp,
                 (m.y >= vs0 && m.y < vs1) ? vp : ~vp};
        return w;
    endfunction

    function automatic logic [23:0] m_pat(input m_t m, input int va);
        logic [23:0] w;
        w = '0;
        if (m.v && m.x < 640 && m.y < va) w = bar_rgb[m.x / 80];
        return w;
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- per-cycle bookkeeping ----------------
    bit acc_a = 1'b0;
    int a_de_cnt, a_hs_low, a_ls_cnt;
    logic a_phs = 1'b1;

    bit   c_fs_seen = 1'b0;
    int   c_since_fs, c_de_in, c_vs_in;
    logic [11:0] c_px, c_py;
    logic c_pvb, c_pvs;

    // One clock: advance model at posedge, compare everything at negedge
    task automatic step();
        bit r;
        @(posedge clk_pix);
        r  = !rst_n;
        ma = m_next(ma, r, 800, 525);
        mb = m_next(mb, r, 800, 8);
        mc = m_next(mc, r, 24, 12);
        if (r) begin
            exp_qa.delete(); repeat (2) exp_qa.push_back(3'b011);
            exp_qb.delete();
            exp_qc.delete(); repeat (3) exp_qc.push_back(3'b011);
            c_fs_seen = 1'b0;
        end
        exp_qa.push_back(m_sync(ma, 640, 480, 656, 752, 490, 492, 1'b0, 1'b0));
`ifdef VIDEO_TIMING_PATTERN_EN
        exp_qb.push_back({m_sync(mb, 640, 4, 656, 752, 5, 7, 1'b1, 1'b1), m_pat(mb, 4)});
`else
        exp_qb.push_back(m_sync(mb, 640, 4, 656, 752, 5, 7, 1'b1, 1'b1));
`endif
        exp_qc.push_back(m_sync(mc, 16, 6, 18, 21, 8, 10, 1'b0, 1'b0));

        @(negedge clk_pix);
        chk("a_undel", 64'({a_x, a_y, a_act, a_ls, a_fs, a_vb}), 64'(m_undel(ma, 640, 480)));
        chk("b_undel", 64'({b_x, b_y, b_act, b_ls, b_fs, b_vb}), 64'(m_undel(mb, 640, 4)));
        chk("c_undel", 64'({c_x, c_y, c_act, c_ls, c_fs, c_vb}), 64'(m_undel(mc, 16, 6)));
        chk("a_dly", 64'({a_de, a_hs, a_vs}), 64'(exp_qa.pop_front()));
`ifdef VIDEO_TIMING_PATTERN_EN
        chk("b_dly", 64'({b_de, b_hs, b_vs, b_pr, b_pg, b_pb}), 64'(exp_qb.pop_front()));
        if (mb.v && mb.y == 0 && mb.x == 80)  chk("b_pat_x80", 64'({b_pr, b_pg, b_pb}), 64'h00FFFF00);
        if (mb.v && mb.y == 0 && mb.x == 639) chk("b_pat_x639", 64'({b_pr, b_pg, b_pb}), 64'h0);
`else
        chk("b_dly", 64'({b_de, b_hs, b_vs}), 64'(exp_qb.pop_front()));
`endif
        chk("c_dly", 64'({c_de, c_hs, c_vs}), 64'(exp_qc.pop_front()));

        // directed timing points, expected values are fixed numbers
        if (a_phs && !a_hs) chk("a_hs_fall_x", 64'(a_x), 64'd658);
        a_phs = a_hs;
        if (mb.v && mb.x == 700) chk("b_hs_high", 64'({b_hs, b_de}), 64'b10);
        if (mb.v && mb.x == 0 && mb.y == 5) chk("b_vs_on", 64'(b_vs), 64'd1);
        if (mb.v && mb.x == 0 && mb.y == 7) chk("b_vs_off", 64'(b_vs), 64'd0);

        if (acc_a) begin
            a_de_cnt += int'(a_de);
            a_hs_low += int'(!a_hs);
            a_ls_cnt += int'(a_ls);
        end

        if (!r && c_pvs && !c_vs) chk("c_vs_fall_xy", 64'({c_x, c_y}), 64'({12'd3, 12'd8}));
        if (!r && c_fs) begin
            if (c_fs_seen) begin
                chk("c_frame_period", 64'(c_since_fs), 64'd288);
                chk("c_frame_de", 64'(c_de_in), 64'd96);
                chk("c_frame_vs_low", 64'(c_vs_in), 64'd48);
                chk("c_wrap", 64'({c_px, c_py, c_pvb, c_vb}), 64'({12'd23, 12'd11, 1'b1, 1'b0}));
            end
            c_fs_seen  = 1'b1;
            c_since_fs = 1;
            c_de_in    = int'(c_de);
            c_vs_in    = int'(!c_vs);
        end else begin
            c_since_fs++;
            c_de_in += int'(c_de);
            c_vs_in += int'(!c_vs);
        end
        c_px = c_x; c_py = c_y; c_pvb = c_vb; c_pvs = c_vs;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bit found;
        ma = '{0, 0, 1'b0}; mb = '{0, 0, 1'b0}; mc = '{0, 0, 1'b0};
        c_pvs = 1'b1;

        // reset state
        rst_n = 1'b0;
        repeat (4) step();
        chk("a_reset", 64'({a_x, a_y, a_act, a_ls, a_fs, a_vb, a_de, a_hs, a_vs}),
            64'({24'd0, 4'b0000, 3'b011}));
        chk("b_reset", 64'({b_de, b_hs, b_vs}), 64'b000);

        // release: first cycle shows (0,0) with both start pulses
        rst_n    = 1'b1;
        acc_a    = 1'b1;
        a_de_cnt = 0; a_hs_low = 0; a_ls_cnt = 0;
        step();
        chk("a_first", 64'({a_fs, a_ls, a_act, a_x, a_y}), 64'({3'b111, 24'd0}));
        chk("a_de_c1", 64'(a_de), 64'd0);
        step();
        chk("a_de_c2", 64'(a_de), 64'd0);
        step();
        chk("a_de_c3", 64'(a_de), 64'd1);

        // six full default lines (cycles 1..4800 after release)
        repeat (4797) step();
        acc_a = 1'b0;
        chk("a_de_total", 64'(a_de_cnt), 64'd3840);
        chk("a_hs_low_total", 64'(a_hs_low), 64'd576);
        chk("a_line_starts", 64'(a_ls_cnt), 64'd6);

        // reset dut_c while its delayed hsync and vsync are both asserted
        found = 1'b0;
        for (int i = 0; i < 400 && !found; i++) begin
            step();
            if (mc.v && mc.x == 22 && mc.y == 8) found = 1'b1;
        end
        chk("c_reach_point", 64'(found), 64'd1);
        chk("c_pre_rst_sync", 64'({c_hs, c_vs}), 64'b00);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("c_in_rst", 64'({c_de, c_hs, c_vs}), 64'b011);
            chk("a_in_rst", 64'({a_de, a_hs, a_vs}), 64'b011);
            chk("b_in_rst", 64'({b_de, b_hs, b_vs}), 64'b000);
        end
        rst_n = 1'b1;
        step();
        chk("c_restart", 64'({c_x, c_y, c_fs}), 64'({24'd0, 1'b1}));

        // two more small frames after the restart
        repeat (600) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
